// File: rtl/ps2_pkg.sv
// ps2_pkg: shared definitions for the PS/2 keyboard receiver.
//   rx_state_e   - receiver FSM states (IDLE, RECV, CHECK)
//   PS2_BRK      - break prefix byte (0xF0)
//   PS2_EXT      - extended prefix byte (0xE0)
//   ps2_entry_t  - 10-bit FIFO entry {is_ext, is_break, code}
//   ps2_parity_ok- odd-parity check over data byte plus parity bit
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_CHECK = 2'd2
    } rx_state_e;

    localparam logic [7:0] PS2_BRK = 8'hF0;
    localparam logic [7:0] PS2_EXT = 8'hE0;

    typedef struct packed {
        logic       is_ext;
        logic       is_break;
        logic [7:0] code;
    } ps2_entry_t;

    // PS/2 uses odd parity: the nine bits together must hold an odd number of ones.
    function automatic logic ps2_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_sync_fifo.sv
// ps2_sync_fifo: single-clock FIFO holding decoded scan-code entries.
//   clk, resetn  - clock, synchronous active-low reset
//   push_i       - write wdata_i (accepted when not full, or when popping in the same cycle)
//   pop_i        - remove head entry (ignored when empty)
//   rdata_o      - head entry
//   full_o/empty_o/level_o - occupancy status
module ps2_sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 10
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push_s;
    logic             do_pop_s;

    assign full_o    = (count_q == FULL_LVL);
    assign empty_o   = (count_q == '0);
    assign do_pop_s  = pop_i & ~empty_o;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign do_push_s = push_i & (~full_o | do_pop_s);
    assign rdata_o   = mem_q[rd_ptr_q];
    assign level_o   = count_q;

    // Storage, pointers (wrap naturally since DEPTH is a power of two) and occupancy.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push_s) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/ps2_kbd_rx.sv
// ps2_kbd_rx: PS/2 keyboard receiver with scan-code prefix decode and output FIFO.
//   clk, resetn          - system clock, synchronous active-low reset
//   ps2_clk, ps2_data    - raw asynchronous PS/2 lines
//   code/is_break/is_ext - head-of-FIFO entry, meaningful while valid
//   valid, ready         - head handshake; entry popped when both high
//   parity_err/frame_err - one-cycle error pulses (frame dropped)
//   overflow, err_clr    - sticky FIFO-drop flag and its clear request
//   level                - FIFO occupancy
module ps2_kbd_rx
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH  = 8,
    parameter int SYNC_STAGES = 3,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          ps2_clk,
    input  logic                          ps2_data,
    output logic [7:0]                    code,
    output logic                          is_break,
    output logic                          is_ext,
    output logic                          valid,
    input  logic                          ready,
    output logic                          parity_err,
    output logic                          frame_err,
    output logic                          overflow,
    input  logic                          err_clr,
    output logic [$clog2(FIFO_DEPTH):0]   level
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYC - 1);

    logic [SYNC_STAGES-1:0] clk_sync_q;
    logic [SYNC_STAGES-1:0] data_sync_q;
    logic                   clk_prev_q;
    logic                   sample_s;
    logic                   bit_s;

    rx_state_e   state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [9:0]  bits_q, bits_d;
    logic [TW-1:0] timer_q, timer_d;
    logic        pend_ext_q, pend_ext_d;
    logic        pend_brk_q, pend_brk_d;
    logic        perr_q, perr_d;
    logic        ferr_q, ferr_d;
    logic        ovf_q, ovf_d;

    logic        push_s;
    ps2_entry_t  push_entry_s;
    ps2_entry_t  head_s;
    logic        pop_s;
    logic        full_s;
    logic        empty_s;

    // Synchronisers idle high, matching the idle level of the PS/2 bus.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            clk_sync_q  <= '1;
            data_sync_q <= '1;
            clk_prev_q  <= 1'b1;
        end else begin
            clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
            data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data};
            clk_prev_q  <= clk_sync_q[SYNC_STAGES-1];
        end
    end

    assign sample_s = clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];
    assign bit_s    = data_sync_q[SYNC_STAGES-1];

    // Receiver state, frame shift register, timeout timer, prefix flags and error pulses.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 4'd0;
            bits_q     <= 10'd0;
            timer_q    <= '0;
            pend_ext_q <= 1'b0;
            pend_brk_q <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bits_q     <= bits_d;
            timer_q    <= timer_d;
            pend_ext_q <= pend_ext_d;
            pend_brk_q <= pend_brk_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            ovf_q      <= ovf_d;
        end
    end

    // Next-state logic: frame reception, validation and prefix decode.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bits_d       = bits_q;
        timer_d      = timer_q;
        pend_ext_d   = pend_ext_q;
        pend_brk_d   = pend_brk_q;
        perr_d       = 1'b0;
        ferr_d       = 1'b0;
        push_s       = 1'b0;
        push_entry_s = '0;
        case (state_q)
            ST_IDLE: begin
                timer_d = '0;
                if (sample_s) begin
                    if (!bit_s) begin
                        state_d = ST_RECV;
                        cnt_d   = 4'd0;
                        bits_d  = 10'd0;
                    end else begin
                        // A falling edge with data high cannot be a start bit.
                        ferr_d     = 1'b1;
                        pend_ext_d = 1'b0;
                        pend_brk_d = 1'b0;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RECV: begin
                if (sample_s) begin
                    bits_d[cnt_q] = bit_s;
                    timer_d       = '0;
                    if (cnt_q == 4'd9) begin
                        state_d = ST_CHECK;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end else if (timer_q == TIMER_LAST) begin
                    state_d    = ST_IDLE;
                    cnt_d      = 4'd0;
                    ferr_d     = 1'b1;
                    pend_ext_d = 1'b0;
                    pend_brk_d = 1'b0;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            ST_CHECK: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
                // bits_q: [7:0] data, [8] parity, [9] stop.
                if (!bits_q[9]) begin
                    ferr_d     = 1'b1;
                    pend_ext_d = 1'b0;
                    pend_brk_d = 1'b0;
                end else if (!ps2_parity_ok(bits_q[7:0], bits_q[8])) begin
                    perr_d     = 1'b1;
                    pend_ext_d = 1'b0;
                    pend_brk_d = 1'b0;
                end else if (bits_q[7:0] == PS2_EXT) begin
                    pend_ext_d = 1'b1;
                end else if (bits_q[7:0] == PS2_BRK) begin
                    pend_brk_d = 1'b1;
                end else begin
                    push_s                = 1'b1;
                    push_entry_s.is_ext   = pend_ext_q;
                    push_entry_s.is_break = pend_brk_q;
                    push_entry_s.code     = bits_q[7:0];
                    pend_ext_d            = 1'b0;
                    pend_brk_d            = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Sticky overflow: a dropped push wins over a same-cycle clear request.
    always_comb begin
        ovf_d = ovf_q;
        if (push_s && full_s && !pop_s) begin
            ovf_d = 1'b1;
        end else if (err_clr) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    assign pop_s = ~empty_s & ready;

    ps2_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(ps2_entry_t))
    ) u_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .push_i  (push_s),
        .wdata_i (push_entry_s),
        .pop_i   (pop_s),
        .rdata_o (head_s),
        .full_o  (full_s),
        .empty_o (empty_s),
        .level_o (level)
    );

    assign code       = head_s.code;
    assign is_break   = head_s.is_break;
    assign is_ext     = head_s.is_ext;
    assign valid      = ~empty_s;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// tb_ps2_kbd_rx: directed plus randomized bench for ps2_kbd_rx with a
// queue-based scan-code model.
module tb_ps2_kbd_rx;

    localparam int DEPTH = 4;
    localparam int SYNC  = 3;
    localparam int TMO   = 200;
    localparam int HALF  = 8;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       ready = 1'b0;
    logic       err_clr = 1'b0;
    logic [7:0] code;
    logic       is_break, is_ext, valid, parity_err, frame_err, overflow;
    logic [2:0] level;

    ps2_kbd_rx #(
        .FIFO_DEPTH  (DEPTH),
        .SYNC_STAGES (SYNC),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .code       (code),
        .is_break   (is_break),
        .is_ext     (is_ext),
        .valid      (valid),
        .ready      (ready),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overflow   (overflow),
        .err_clr    (err_clr),
        .level      (level)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int perr_seen = 0;
    int ferr_seen = 0;

    // Count every cycle an error pulse is high; a stuck pulse inflates the count.
    always @(posedge clk) begin
        if (parity_err) perr_seen <= perr_seen + 1;
        if (frame_err)  ferr_seen <= ferr_seen + 1;
    end

    // Reference model: expected FIFO contents {ext, brk, code}, prefix flags, sticky overflow.
    logic [9:0] exp_q[$];
    bit         m_ext = 1'b0;
    bit         m_brk = 1'b0;
    bit         m_ovf = 1'b0;
    int         exp_perr = 0;
    int         exp_ferr = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_frame(input logic [7:0] d, input bit par_ok, input bit stop_ok);
        if (!stop_ok) begin
            exp_ferr++; m_ext = 1'b0; m_brk = 1'b0;
        end else if (!par_ok) begin
            exp_perr++; m_ext = 1'b0; m_brk = 1'b0;
        end else if (d == 8'hE0) begin
            m_ext = 1'b1;
        end else if (d == 8'hF0) begin
            m_brk = 1'b1;
        end else begin
            if (exp_q.size() < DEPTH) exp_q.push_back({m_ext, m_brk, d});
            else m_ovf = 1'b1;
            m_ext = 1'b0; m_brk = 1'b0;
        end
    endtask

    task automatic ps2_edge(input logic b);
        @(negedge clk) ps2_data = b;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    // mode 0: plain frame; 1: check valid latency (FIFO empty);
    // 2: pulse ready during the CHECK cycle (collision with a full FIFO).
    task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop, input int mode);
        logic par;
        par = ~(^d) ^ bad_par;
        ps2_edge(1'b0);
        for (int i = 0; i < 8; i++) ps2_edge(d[i]);
        ps2_edge(par);
        @(negedge clk) ps2_data = ~bad_stop;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        // SYNC edges to reach the synchroniser output, one for the sample event, one into CHECK.
        repeat (SYNC + 1) @(negedge clk);
        if (mode == 1) check("latency_in_check", valid, 1'b0);
        if (mode == 2) begin
            check("collide_head", {is_ext, is_break, code}, exp_q[0]);
            ready = 1'b1;
        end
        @(negedge clk);
        if (mode == 1) check("latency_valid", valid, 1'b1);
        if (mode == 2) begin
            ready = 1'b0;
            void'(exp_q.pop_front());
        end
        model_frame(d, !bad_par, !bad_stop);
        repeat (HALF - SYNC - 2) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic check_state(input string tag);
        repeat (4) @(negedge clk);
        check({tag, "_level"}, level, exp_q.size());
        check({tag, "_valid"}, valid, exp_q.size() != 0);
        check({tag, "_ovf"}, overflow, m_ovf);
        check({tag, "_perr"}, perr_seen, exp_perr);
        check({tag, "_ferr"}, ferr_seen, exp_ferr);
        if (exp_q.size() != 0) check({tag, "_head"}, {is_ext, is_break, code}, exp_q[0]);
    endtask

    task automatic pop_check(input string tag);
        @(negedge clk);
        check({tag, "_pop_valid"}, valid, 1'b1);
        check({tag, "_pop_head"}, {is_ext, is_break, code}, exp_q[0]);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        void'(exp_q.pop_front());
    endtask

    task automatic drain(input string tag);
        while (exp_q.size() != 0) pop_check(tag);
        @(negedge clk);
        check({tag, "_drained_level"}, level, 3'd0);
        check({tag, "_drained_valid"}, valid, 1'b0);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_valid"}, valid, 1'b0);
        check({tag, "_level"}, level, 3'd0);
        check({tag, "_code"}, {is_ext, is_break, code}, 10'd0);
        check({tag, "_ovf"}, overflow, 1'b0);
        check({tag, "_errs"}, {parity_err, frame_err}, 2'b00);
    endtask

    // Watchdog: the stimulus is fixed-length, this only guards against a stuck run.
    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] rb;
        int         pre;
        bit         bp;

        resetn = 1'b0;
        repeat (4) @(negedge clk);
        check_reset("reset");
        resetn = 1'b1;
        repeat (4) @(negedge clk);

        // Single make code, valid two cycles after the stop sample event.
        send_frame(8'h1C, 1'b0, 1'b0, 1);
        check_state("single");
        drain("single");

        // Break and extended-break sequences.
        send_frame(8'hF0, 1'b0, 1'b0, 0);
        send_frame(8'h1C, 1'b0, 1'b0, 0);
        send_frame(8'hE0, 1'b0, 1'b0, 0);
        send_frame(8'hF0, 1'b0, 1'b0, 0);
        send_frame(8'h75, 1'b0, 1'b0, 0);
        check_state("prefix");
        drain("prefix");

        // Parity error drops the frame and the pending break prefix.
        send_frame(8'hF0, 1'b0, 1'b0, 0);
        send_frame(8'h1C, 1'b1, 1'b0, 0);
        send_frame(8'h1C, 1'b0, 1'b0, 0);
        check_state("parity");
        drain("parity");

        // Bad start bit and bad stop bit both clear prefixes.
        send_frame(8'hF0, 1'b0, 1'b0, 0);
        ps2_edge(1'b1);
        exp_ferr++; m_ext = 1'b0; m_brk = 1'b0;
        send_frame(8'h1C, 1'b0, 1'b0, 0);
        send_frame(8'hE0, 1'b0, 1'b0, 0);
        send_frame(8'h1C, 1'b0, 1'b1, 0);
        send_frame(8'h2A, 1'b0, 1'b0, 0);
        check_state("framing");
        drain("framing");

        // Overflow with ready low, then clear, then a push/pop collision while full.
        send_frame(8'h15, 1'b0, 1'b0, 0);
        send_frame(8'h16, 1'b0, 1'b0, 0);
        send_frame(8'h1A, 1'b0, 1'b0, 0);
        send_frame(8'h1B, 1'b0, 1'b0, 0);
        send_frame(8'h21, 1'b0, 1'b0, 0);
        check_state("overflow");
        @(negedge clk) err_clr = 1'b1;
        @(negedge clk) err_clr = 1'b0;
        m_ovf = 1'b0;
        check("overflow_cleared", overflow, 1'b0);
        send_frame(8'h29, 1'b0, 1'b0, 2);
        check_state("collide");
        drain("collide");

        // Timeout mid-frame after five bits; next frame decodes normally.
        send_frame(8'hE0, 1'b0, 1'b0, 0);
        ps2_edge(1'b0);
        for (int i = 0; i < 4; i++) ps2_edge(1'b1);
        repeat (TMO + 20) @(negedge clk);
        exp_ferr++; m_ext = 1'b0; m_brk = 1'b0;
        send_frame(8'h32, 1'b0, 1'b0, 0);
        check_state("timeout");
        drain("timeout");

        // Randomized codes with random prefixes and occasional parity faults.
        for (int it = 0; it < 10; it++) begin
            rb  = 8'($urandom_range(0, 255));
            pre = $urandom_range(0, 3);
            bp  = ($urandom_range(0, 7) == 0);
            if (pre == 1 || pre == 3) send_frame(8'hE0, 1'b0, 1'b0, 0);
            if (pre == 2 || pre == 3) send_frame(8'hF0, 1'b0, 1'b0, 0);
            send_frame(rb, bp, 1'b0, 0);
            check_state("random");
            if (exp_q.size() >= DEPTH - 1 || $urandom_range(0, 1) == 1) drain("random");
        end
        drain("random_end");

        // Reset in the middle of a frame; first frame afterwards decodes cleanly.
        send_frame(8'hE0, 1'b0, 1'b0, 0);
        ps2_edge(1'b0);
        for (int i = 0; i < 5; i++) ps2_edge(1'b0);
        @(negedge clk) resetn = 1'b0;
        repeat (2) @(negedge clk);
        check_reset("midreset");
        resetn = 1'b1;
        exp_q.delete(); m_ext = 1'b0; m_brk = 1'b0; m_ovf = 1'b0;
        repeat (4) @(negedge clk);
        send_frame(8'h1C, 1'b0, 1'b0, 0);
        check_state("postreset");
        drain("postreset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ps2_kbd_rx.md
PS2_KBD_RX -- requirements
Module: ps2_kbd_rx

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, scan-code FIFO entries (power of 2, >= 2).
REQ-002 SHALL have parameter SYNC_STAGES, default 3, ps2_clk/ps2_data synchroniser depth (>= 2).
REQ-003 SHALL have parameter TIMEOUT_CYC, default 100000, max clk cycles between ps2_clk falling edges inside a frame.
REQ-004 clk  input  1  system clock; all logic on posedge clk.
REQ-005 resetn  input  1  reset, synchronous, active-low.
REQ-006 ps2_clk  input  1  raw PS/2 clock, asynchronous.
REQ-007 ps2_data  input  1  raw PS/2 data, asynchronous.
REQ-008 code  output  8  head-of-FIFO scan code.
REQ-009 is_break  output  1  head code was preceded by 0xF0.
REQ-010 is_ext  output  1  head code was preceded by 0xE0.
REQ-011 valid  output  1  FIFO non-empty; code/is_break/is_ext are meaningful.
REQ-012 ready  input  1  consumer accepts head entry when valid && ready.
REQ-013 parity_err  output  1  one-cycle pulse, frame dropped for parity.
REQ-014 frame_err  output  1  one-cycle pulse, bad start, bad stop or timeout.
REQ-015 overflow  output  1  sticky: a decoded code was dropped because FIFO full.
REQ-016 err_clr  input  1  one-cycle request to clear overflow.
REQ-017 level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-018 ps2_clk and ps2_data SHALL each pass SYNC_STAGES flops; a sample event SHALL be the cycle the synchronised ps2_clk goes 1 -> 0.
REQ-019 Receiver FSM SHALL have states IDLE, RECV, CHECK.
REQ-020 IDLE: sample event with data=0 -> RECV, bit counter=0; sample event with data=1 -> stay IDLE, pulse frame_err.
REQ-021 RECV: each sample event shifts data into bits[counter] (8 data LSB first, then parity, then stop); after the 10th (stop) bit -> CHECK.
REQ-022 RECV: TIMEOUT_CYC cycles without a sample event -> IDLE, pulse frame_err, discard partial frame.
REQ-023 CHECK (one cycle): stop=0 -> frame_err; else XOR(data,parity)=0 -> parity_err; else decode; always -> IDLE.
REQ-024 Decode: 0xE0 sets pending_ext, 0xF0 sets pending_brk, neither pushed; any other byte pushed as {pending_ext,pending_brk,byte}, then both pending flags cleared.
REQ-025 A frame error or parity error SHALL clear pending_ext and pending_brk.
REQ-026 Push SHALL occur in the CHECK cycle; valid SHALL rise the next cycle when FIFO was empty (2 cycles after the stop-bit sample event).
REQ-027 Pop when valid && ready; code/flags show the next entry the following cycle.
REQ-028 Push and pop in the same cycle SHALL both succeed, including when full; level unchanged.
REQ-029 Push when full without pop: entry dropped, overflow set; set has priority over same-cycle err_clr.
REQ-030 Read/write pointers SHALL wrap modulo FIFO_DEPTH; level SHALL never exceed FIFO_DEPTH.

Reset
REQ-031 With resetn=0 at a clk edge: FSM=IDLE, counter=0, pending flags=0, FIFO empty, valid=0, level=0, overflow=0, parity_err=0, frame_err=0, code=0, is_break=0, is_ext=0; synchroniser flops=1.
REQ-032 Reset mid-frame SHALL discard the partial frame; the first post-reset frame SHALL decode normally.

Structure
REQ-033 Shared package ps2_pkg SHALL hold the FSM state enum, PS2_BRK=8'hF0, PS2_EXT=8'hE0 and the 10-bit FIFO entry type.
REQ-034 FIFO SHALL be sub-module ps2_sync_fifo (parameters DEPTH, WIDTH); synchroniser, FSM and decode stay in ps2_kbd_rx.

Verification
REQ-035 Frame 0x1C, odd parity 0, stop 1 -> one entry code=0x1C, is_break=0, is_ext=0; valid 2 cycles after stop sample event.
REQ-036 Frames F0,1C then E0,F0,75 -> entries {0x1C,brk=1,ext=0}, {0x75,brk=1,ext=1}; level=2 with ready=0.
REQ-037 Frame 0x1C, parity bit 1 -> parity_err pulse, no push; following F0 prefix state cleared.
REQ-038 FIFO_DEPTH=4, ready=0, send 5 codes -> level=4, overflow=1, first 4 codes retained in order; err_clr -> overflow=0.
REQ-039 Send 5 bits then hold ps2_clk high TIMEOUT_CYC cycles -> frame_err pulse, FSM IDLE; next full frame 0x32 decoded.
REQ-040 FIFO full, ready=1 during CHECK of a new frame -> pop and push same cycle, level stays 4, overflow=0.
